// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the receive handshake states.
// The transmit-side block is expected to import this package as well.
package uart_pkg;

  localparam int UART_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    RELEASE
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with show-ahead read.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Qualify requests: pops on an empty buffer and pushes into a full one are ignored.
  always_comb begin
    push_ok = push & ~full;
    pop_ok  = pop & ~empty;
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Show-ahead read port and status flags derived from the registered count.
  always_comb begin
    dout  = mem[rd_ptr];
    full  = (count == CW'(DEPTH));
    empty = (count == '0);
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive front end: rxready/rxclk handshake with the host feeding a
// small FIFO that is drained through a valid/ready stream.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       hz100,
  input  logic                       reset,
  input  logic [UART_W-1:0]          rxdata,
  input  logic                       rxready,
  output logic                       rxclk,
  output logic [UART_W-1:0]          dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  rx_state_t state;
  rx_state_t state_next;
  logic      push;
  logic      pop;
  logic      empty;

  // Handshake state register; reset drops rxclk immediately since rxclk decodes state.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: accept only when there is room, then wait for the host to let go.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rxready && !full) state_next = ACK;
      ACK:     state_next = RELEASE;
      RELEASE: if (!rxready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: the single ACK cycle both strobes the host and writes the byte.
  always_comb begin
    rxclk = (state == ACK);
    push  = (state == ACK);
  end

  // Consumer side glue: a pop only happens when a byte is actually present.
  always_comb begin
    dout_valid = ~empty;
    pop        = dout_valid & dout_ready;
  end

  sync_fifo #(
    .WIDTH (UART_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (hz100),
    .rst   (reset),
    .push  (push),
    .din   (rxdata),
    .pop   (pop),
    .dout  (dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a cycle table for the basic handshake
// followed by hand-written sequences for backpressure, wrap, push/pop and reset.
module tb_uart_rx_fifo;

  logic       hz100;
  logic       reset;
  logic [7:0] rxdata;
  logic       rxready;
  logic       rxclk;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [3:0] count;
  logic       full;

  int vec_count;
  int err_count;

  typedef struct {
    logic       rxready;
    logic [7:0] rxdata;
    logic       dout_ready;
    logic       exp_rxclk;
    logic       exp_valid;
    logic [7:0] exp_dout;
    logic [3:0] exp_count;
    logic       exp_full;
  } vec_t;

  vec_t vecs[$];

  uart_rx_fifo #(.DEPTH(8)) dut (
    .hz100      (hz100),
    .reset      (reset),
    .rxdata     (rxdata),
    .rxready    (rxready),
    .rxclk      (rxclk),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count),
    .full       (full)
  );

  // Free-running system clock
  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  function automatic void addVec(logic rr, logic [7:0] rd, logic dr, logic ec,
                                 logic ev, logic [7:0] ed, logic [3:0] en, logic ef);
    vec_t v;
    v.rxready = rr; v.rxdata = rd; v.dout_ready = dr;
    v.exp_rxclk = ec; v.exp_valid = ev; v.exp_dout = ed;
    v.exp_count = en; v.exp_full = ef;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One table row: drive inputs mid-cycle, step one edge, check just after it
  task automatic applyStimulus(vec_t v, int idx);
    @(negedge hz100);
    rxready    = v.rxready;
    rxdata     = v.rxdata;
    dout_ready = v.dout_ready;
    @(posedge hz100);
    #1;
    checkOutput($sformatf("vec%0d rxclk", idx), 32'(rxclk), 32'(v.exp_rxclk));
    checkOutput($sformatf("vec%0d dout_valid", idx), 32'(dout_valid), 32'(v.exp_valid));
    checkOutput($sformatf("vec%0d count", idx), 32'(count), 32'(v.exp_count));
    checkOutput($sformatf("vec%0d full", idx), 32'(full), 32'(v.exp_full));
    if (v.exp_valid)
      checkOutput($sformatf("vec%0d dout", idx), 32'(dout), 32'(v.exp_dout));
  endtask

  // Full host handshake for one byte, with a bounded wait for rxclk
  task automatic sendByte(logic [7:0] b);
    bit seen;
    seen = 0;
    @(negedge hz100);
    rxready = 1'b1;
    rxdata  = b;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge hz100);
      #1;
      if (rxclk) seen = 1;
    end
    if (!seen) checkOutput($sformatf("rxclk timeout byte %0h", b), 32'(seen), 32'd1);
    @(negedge hz100);
    rxready = 1'b0;
    repeat (2) @(posedge hz100);
  endtask

  // Check the head byte, then pop it on the next edge
  task automatic popExpect(logic [7:0] b);
    @(negedge hz100);
    checkOutput($sformatf("pop valid %0h", b), 32'(dout_valid), 32'd1);
    checkOutput($sformatf("pop data %0h", b), 32'(dout), 32'(b));
    dout_ready = 1'b1;
  endtask

  task automatic popDone();
    @(negedge hz100);
    dout_ready = 1'b0;
  endtask

  logic [7:0] popped[$];

  initial begin
    vec_count  = 0;
    err_count  = 0;
    reset      = 1'b1;
    rxready    = 1'b0;
    rxdata     = 8'h00;
    dout_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge hz100);
    #1;
    checkOutput("reset rxclk", 32'(rxclk), 32'd0);
    checkOutput("reset count", 32'(count), 32'd0);
    checkOutput("reset dout_valid", 32'(dout_valid), 32'd0);
    checkOutput("reset full", 32'(full), 32'd0);
    @(negedge hz100);
    reset = 1'b0;

    // Single byte 41, then a sticky host with 42, then 43 after a clean re-raise
    addVec(1, 8'h41, 0, 1, 0, 8'h00, 0, 0);
    addVec(0, 8'h41, 0, 0, 1, 8'h41, 1, 0);
    addVec(0, 8'h41, 1, 0, 0, 8'h00, 0, 0);
    addVec(1, 8'h42, 0, 1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++) addVec(1, 8'h42, 0, 0, 1, 8'h42, 1, 0);
    addVec(0, 8'h42, 0, 0, 1, 8'h42, 1, 0);
    addVec(1, 8'h43, 0, 1, 1, 8'h42, 1, 0);
    addVec(0, 8'h43, 0, 0, 1, 8'h42, 2, 0);
    addVec(0, 8'h43, 1, 0, 1, 8'h43, 1, 0);
    addVec(0, 8'h43, 1, 0, 0, 8'h00, 0, 0);
    addVec(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // Fill to full, then hold 08 under backpressure
    for (int i = 0; i < 8; i++) sendByte(8'(i));
    #1;
    checkOutput("fill count", 32'(count), 32'd8);
    checkOutput("fill full", 32'(full), 32'd1);
    begin
      bit saw;
      saw = 0;
      @(negedge hz100);
      rxready = 1'b1;
      rxdata  = 8'h08;
      for (int i = 0; i < 6; i++) begin
        @(posedge hz100);
        #1;
        if (rxclk) saw = 1;
      end
      checkOutput("backpressure no rxclk", 32'(saw), 32'd0);
      checkOutput("backpressure full", 32'(full), 32'd1);
      popExpect(8'h00);
      popDone();
      saw = 0;
      for (int i = 0; i < 5 && !saw; i++) begin
        @(posedge hz100);
        #1;
        if (rxclk) saw = 1;
      end
      checkOutput("accept after pop", 32'(saw), 32'd1);
      @(negedge hz100);
      rxready = 1'b0;
      repeat (2) @(posedge hz100);
      #1;
      checkOutput("refill count", 32'(count), 32'd8);
    end
    for (int i = 1; i <= 8; i++) popExpect(8'(i));
    popDone();
    #1;
    checkOutput("drain count", 32'(count), 32'd0);

    // Wrap-around stream with a consumer ready every other cycle
    popped.delete();
    fork
      begin
        for (int i = 0; i < 20; i++) sendByte(8'h10 + 8'(i));
      end
      begin
        bit r;
        r = 0;
        for (int c = 0; c < 800 && popped.size() < 20; c++) begin
          @(negedge hz100);
          r = ~r;
          dout_ready = r;
          if (r && dout_valid) popped.push_back(dout);
        end
        @(negedge hz100);
        dout_ready = 1'b0;
      end
    join
    checkOutput("wrap pop total", 32'(popped.size()), 32'd20);
    for (int i = 0; i < popped.size(); i++)
      checkOutput($sformatf("wrap byte %0d", i), 32'(popped[i]), 32'h10 + 32'(i));
    #1;
    checkOutput("wrap final count", 32'(count), 32'd0);

    // Simultaneous push and pop at count 3
    sendByte(8'ha0);
    sendByte(8'ha1);
    sendByte(8'ha2);
    @(negedge hz100);
    rxready = 1'b1;
    rxdata  = 8'ha3;
    @(posedge hz100);
    #1;
    checkOutput("pushpop rxclk", 32'(rxclk), 32'd1);
    checkOutput("pushpop count before", 32'(count), 32'd3);
    @(negedge hz100);
    dout_ready = 1'b1;
    rxready    = 1'b0;
    @(posedge hz100);
    #1;
    checkOutput("pushpop count after", 32'(count), 32'd3);
    checkOutput("pushpop head", 32'(dout), 32'ha1);
    @(negedge hz100);
    dout_ready = 1'b0;
    popExpect(8'ha1);
    popExpect(8'ha2);
    popExpect(8'ha3);
    popDone();
    #1;
    checkOutput("pushpop drained", 32'(count), 32'd0);

    // Reset in the middle of an ACK with five bytes buffered
    for (int i = 0; i < 5; i++) sendByte(8'hb0 + 8'(i));
    @(negedge hz100);
    rxready = 1'b1;
    rxdata  = 8'hb5;
    @(posedge hz100);
    #1;
    checkOutput("midack rxclk", 32'(rxclk), 32'd1);
    checkOutput("midack count", 32'(count), 32'd5);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async reset rxclk", 32'(rxclk), 32'd0);
    checkOutput("async reset count", 32'(count), 32'd0);
    checkOutput("async reset dout_valid", 32'(dout_valid), 32'd0);
    @(negedge hz100);
    reset = 1'b0;
    @(posedge hz100);
    #1;
    checkOutput("restart rxclk", 32'(rxclk), 32'd1);
    @(negedge hz100);
    rxready = 1'b0;
    @(posedge hz100);
    #1;
    checkOutput("restart count", 32'(count), 32'd1);
    checkOutput("restart dout", 32'(dout), 32'hb5);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
